// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants and types for the HI/LO sequencer.
// Revision: 1.0
`default_nettype none

package hilo_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MUL_WAIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: core-side request/stall/read-data bundle of hilo_ctrl.
// Revision: 1.0
`default_nettype none

interface hilo_ctrl_if;
  import hilo_pkg::*;

  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              busy;
  logic [DATA_W-1:0] mf_data;

  modport master (output op_valid, op, rs_data, rt_data, input busy, mf_data);
  modport slave  (input op_valid, op, rs_data, rt_data, output busy, mf_data);

endinterface

`default_nettype wire

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: MULT/DIV operand capture, settle-latency sequencer and HI/LO pair.
// Optional macro HILO_DIVZERO_TRAP_EN: suppress HI/LO write and pulse div_zero on zero divisor. Revision: 1.0
`default_nettype none

module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DIV_LAT = 4,
  parameter int MUL_LAT = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  hilo_ctrl_if.slave             core,
  input  wire logic [DATA_W-1:0] div_q,
  input  wire logic [DATA_W-1:0] div_r,
  input  wire logic [DATA_W-1:0] mul_hi,
  input  wire logic [DATA_W-1:0] mul_lo,
  output logic      [DATA_W-1:0] opa,
  output logic      [DATA_W-1:0] opb,
  output logic                   div_ena,
  output logic      [DATA_W-1:0] hi,
  output logic      [DATA_W-1:0] lo,
  output logic                   div_zero
);

  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] hi_n, lo_n, opa_n, opb_n;
`ifdef HILO_DIVZERO_TRAP_EN
  logic              dz_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      opa   <= opa_n;
      opb   <= opb_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    opa_n   = opa;
    opb_n   = opb;
`ifdef HILO_DIVZERO_TRAP_EN
    dz_n    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (core.op_valid) begin
          case (core.op)
            OP_MULT: begin
              opa_n   = core.rs_data;
              opb_n   = core.rt_data;
              cnt_n   = MUL_CNT;
              state_n = ST_MUL_WAIT;
            end
            OP_DIV: begin
              opa_n   = core.rs_data;
              opb_n   = core.rt_data;
              cnt_n   = DIV_CNT;
              state_n = ST_DIV_WAIT;
            end
            OP_MTHI: hi_n = core.rs_data;
            OP_MTLO: lo_n = core.rs_data;
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          hi_n    = mul_hi;
          lo_n    = mul_lo;
          state_n = ST_IDLE;
        end
      end
      ST_DIV_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
`ifdef HILO_DIVZERO_TRAP_EN
          if (opb == '0) begin
            dz_n = 1'b1;
          end else begin
            hi_n = div_r;
            lo_n = div_q;
          end
`else
          hi_n = div_r;
          lo_n = div_q;
`endif
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef HILO_DIVZERO_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) div_zero <= 1'b0;
    else       div_zero <= dz_n;
  end
`else
  assign div_zero = 1'b0;
`endif

  assign div_ena   = (state == ST_DIV_WAIT);
  assign core.busy = (state != ST_IDLE);

  // Read port follows the op field directly so MF sees the just-written value.
  always_comb begin
    case (core.op)
      OP_MFHI: core.mf_data = hi;
      OP_MFLO: core.mf_data = lo;
      default: core.mf_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and random checks of hilo_ctrl against an arithmetic model.
// Revision: 1.0
`default_nettype none

module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int DIV_LAT = 4;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] div_q, div_r, mul_hi, mul_lo, opa, opb, hi, lo;
  logic div_ena, div_zero;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  hilo_ctrl_if core ();

  hilo_ctrl #(.DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .core(core),
    .div_q(div_q), .div_r(div_r), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .opa(opa), .opb(opb), .div_ena(div_ena), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return 32'($signed(a) / $signed(b));
  endfunction

  function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return a;
    return 32'($signed(a) % $signed(b));
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Stand-in combinational divider and multiplier fed by the DUT operand registers.
  always_comb begin
    logic [63:0] p;
    p      = smul(opa, opb);
    mul_hi = p[63:32];
    mul_lo = p[31:0];
    div_q  = sdiv(opa, opb);
    div_r  = srem(opa, opb);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    int lat;
    logic [31:0] eh, el;
    logic edz;
    logic [63:0] p;
    core.op_valid = 1'b1;
    core.op       = o;
    core.rs_data  = a;
    core.rt_data  = b;
    #1;
    if (o == OP_MFHI)      chk("mfhi", core.mf_data, m_hi);
    else if (o == OP_MFLO) chk("mflo", core.mf_data, m_lo);
    else                   chk("mf_other", core.mf_data, 32'd0);
    tick();
    core.op_valid = 1'b0;
    core.op       = OP_NOP;
    eh = m_hi; el = m_lo; edz = 1'b0; lat = 0;
    case (o)
      OP_MULT: begin
        p = smul(a, b); eh = p[63:32]; el = p[31:0]; lat = MUL_LAT;
      end
      OP_DIV: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin
`ifdef HILO_DIVZERO_TRAP_EN
          edz = 1'b1;
`else
          eh = a; el = 32'hFFFF_FFFF;
`endif
        end else begin
          eh = srem(a, b); el = sdiv(a, b);
        end
      end
      OP_MTHI: eh = a;
      OP_MTLO: el = a;
      default: ;
    endcase
    if (lat > 0) begin
      chk("opa", opa, a);
      chk("opb", opb, b);
      chk("div_ena", {31'd0, div_ena}, {31'd0, o == OP_DIV});
    end
    n = 0;
    while (core.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy_cycles", 32'(n), 32'(lat));
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_zero", {31'd0, div_zero}, {31'd0, edz});
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [2:0] o;
    logic [31:0] a, b;
    reset = 1'b1;
    core.op_valid = 1'b0;
    core.op = OP_NOP;
    core.rs_data = '0;
    core.rt_data = '0;
    m_hi = '0;
    m_lo = '0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_opa", opa, 32'd0);
    chk("rst_opb", opb, 32'd0);
    chk("rst_busy", {31'd0, core.busy}, 32'd0);
    chk("rst_div_ena", {31'd0, div_ena}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst_mf", core.mf_data, 32'd0);
    run_op(OP_MFHI, 32'd0, 32'd0);
    run_op(OP_MFLO, 32'd0, 32'd0);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_hi", hi, 32'hFFFF_FFFF);

    // MULT with a DIV request held throughout the busy window.
    core.op_valid = 1'b1; core.op = OP_MULT;
    core.rs_data = 32'h0001_0000; core.rt_data = 32'h0001_0000;
    tick();
    core.op = OP_DIV; core.rs_data = 32'd9; core.rt_data = 32'd3;
    n = 0;
    while (core.busy === 1'b1 && n < 40) begin n++; tick(); end
    chk("mul_busy_cycles", 32'(n), 32'(MUL_LAT));
    chk("mul_hi", hi, 32'h0000_0001);
    chk("mul_lo", lo, 32'h0000_0000);
    chk("opa_held", opa, 32'h0001_0000);
    tick();
    core.op_valid = 1'b0; core.op = OP_NOP;
    chk("div93_opa", opa, 32'd9);
    n = 0;
    while (core.busy === 1'b1 && n < 40) begin n++; tick(); end
    chk("div93_busy_cycles", 32'(n), 32'(DIV_LAT));
    chk("div93_lo", lo, 32'd3);
    chk("div93_hi", hi, 32'd0);
    m_hi = 32'd0; m_lo = 32'd3;

    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    run_op(OP_MTLO, 32'h1234_5678, 32'd0);
    run_op(OP_MFHI, 32'd0, 32'd0);
    run_op(OP_MFLO, 32'd0, 32'd0);
    chk("mt_hi", hi, 32'hDEAD_BEEF);

    run_op(OP_DIV, 32'd5, 32'd0);
    run_op(OP_MFHI, 32'd0, 32'd0);

    // Random sequence; divisor -1 skipped to avoid the INT_MIN/-1 overflow.
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      run_op(o, a, b);
    end

    // Reset in the second busy cycle of a DIV aborts it.
    run_op(OP_MTHI, 32'h5555_AAAA, 32'd0);
    core.op_valid = 1'b1; core.op = OP_DIV;
    core.rs_data = 32'd100; core.rt_data = 32'd7;
    tick();
    core.op_valid = 1'b0; core.op = OP_NOP;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, core.busy}, 32'd0);
    chk("abort_div_ena", {31'd0, div_ena}, 32'd0);
    chk("abort_opa", opa, 32'd0);
    for (int i = 0; i < DIV_LAT + 2; i++) tick();
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);
    chk("abort_late_busy", {31'd0, core.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer and HI/LO register pair on the multiply/divide path of the CPU. It captures MULT/DIV operands from the register file and holds them stable on the combinational divider's and multiplier's inputs. After a fixed per-operation settle latency it latches the results into HI/LO and serves MFHI/MFLO/MTHI/MTLO. A `busy` output lets the core stall while a result is in flight.

## Interface
- `DIV_LAT`, 4: cycles from DIV acceptance to HI/LO update; legal 1..15.
- `MUL_LAT`, 2: cycles from MULT acceptance to HI/LO update; legal 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `op_valid` in 1: operation request.
- `op` in 3: 0 NOP, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as NOP).
- `rs_data` in 32: dividend / multiplicand / MT source.
- `rt_data` in 32: divisor / multiplier.
- `div_q`, `div_r` in 32 each: divider quotient and remainder.
- `mul_hi`, `mul_lo` in 32 each: signed product halves.
- `opa`, `opb` out 32 each: registered operands to divider and multiplier.
- `div_ena` out 1: divider enable.
- `busy` out 1: result pending; the core stalls.
- `hi`, `lo` out 32 each: architectural HI/LO.
- `mf_data` out 32: MFHI/MFLO read data.
- `div_zero` out 1: one-cycle divide-by-zero pulse.

## Operation
- FSM states: IDLE, DIV_WAIT, MUL_WAIT.
- A request is accepted only in IDLE with `op_valid`=1.
- While `busy`=1, `op_valid` is ignored. The core holds the instruction until `busy`=0.
- IDLE + MULT: `opa`<=rs, `opb`<=rt, `cnt`<=MUL_LAT-1, go to MUL_WAIT.
- IDLE + DIV: `opa`<=rs, `opb`<=rt, `cnt`<=DIV_LAT-1, go to DIV_WAIT.
- WAIT states:
  - If `cnt`!=0, decrement it.
  - If `cnt`=0: latch HI<=`mul_hi`/`div_r` and LO<=`mul_lo`/`div_q`, then return to IDLE.
- `cnt` is 4 bits.
- `div_ena`=1 only in DIV_WAIT. Otherwise it is 0.
- `opa`/`opb` hold their value outside accept cycles.
- MTHI/MTLO in IDLE: HI or LO <= rs at that edge; no busy.
- MFHI/MFLO: `mf_data` is combinational `hi`/`lo`, valid in the same cycle when `busy`=0.
- `mf_data`=0 for any other op.
- `busy`=1 in DIV_WAIT and MUL_WAIT.
- NOP and reserved ops have no effect.

## Timing
- Reset values: HI=0, LO=0, `opa`=`opb`=0, state IDLE, `cnt`=0, `busy`=0, `div_ena`=0, `div_zero`=0, `mf_data`=0.
- Acceptance at edge T:
  - `busy` is high for cycles T+1 .. T+LAT.
  - HI/LO take new values at edge T+LAT.
  - `busy` falls in the same cycle the new HI/LO become visible.
- LAT=1: exactly one busy cycle; the update happens at the next edge.
- Back-to-back: a new op can be accepted in the first cycle `busy`=0. An MFHI in that cycle returns the new value.
- Reset mid-operation: abort, no HI/LO update, all reset values next cycle.
- HI/LO are never partially updated; both halves are written at the same edge.

## Configuration
- `HILO_DIVZERO_TRAP_EN` defined:
  - The block detects `opb`==0 at DIV completion.
  - HI/LO are left unchanged.
  - `div_zero` pulses 1 for the cycle following that edge.
- `HILO_DIVZERO_TRAP_EN` not defined:
  - HI/LO take `div_r`/`div_q` as produced, even for a zero divisor.
  - `div_zero` is tied to 0.

## Structure
- Package `hilo_pkg` holds:
  - the `op` encoding localparams (OP_NOP..OP_MFLO);
  - the FSM state typedef;
  - the 4-bit counter width constant.
- Single module; no sub-module.
- The latency counter stays inline.

## Test plan
- Reset, then MFHI and MFLO: `mf_data`=0 both times; `busy`=0.
- DIV rs=-7, rt=2, DIV_LAT=4, real divider attached:
  - `busy` is high for exactly 4 cycles;
  - then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULT rs=0x00010000, rt=0x00010000, MUL_LAT=2:
  - `busy` is high for 2 cycles;
  - then HI=0x00000001, LO=0x00000000.
  - With `op_valid`=1 and op=DIV, rs=9, rt=3 during busy: the DIV is ignored until busy falls, then accepted.
- MTHI 0xDEADBEEF, MTLO 0x12345678, then MFHI/MFLO: `mf_data`=0xDEADBEEF, then 0x12345678; no busy cycles.
- DIV rs=5, rt=0:
  - with `HILO_DIVZERO_TRAP_EN` defined: HI/LO unchanged and one `div_zero` pulse;
  - without it: no pulse, and HI/LO equal the divider outputs.
- DIV accepted, then `reset` asserted in the 2nd busy cycle: next cycle HI=LO=0, `busy`=0, state IDLE, and no late update.
